// File: rtl/bcd_digit_scanner_pkg.sv
// Shared constants and types for the BCD digit scanner: place indices, FSM encoding,
// the packed three-digit display type and the per-nibble double-dabble correction.
package bcd_digit_scanner_pkg;

   localparam logic [1:0] PLACE_ONES     = 2'd0;
   localparam logic [1:0] PLACE_TENS     = 2'd1;
   localparam logic [1:0] PLACE_HUNDREDS = 2'd2;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_COMMIT  = 2'd2;

   localparam int ITERATIONS = 8;

   typedef struct packed {
      logic [3:0] hundreds;
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_t;

   // A nibble of 5 or more would exceed 9 after doubling, so pre-add 3.
   function automatic logic [3:0] add3_adjust(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_digit_scanner_dabble_step.sv
// One double-dabble iteration: correct each BCD nibble, then shift {scratch, bin} left by one.
module bcd_digit_scanner_dabble_step
   import bcd_digit_scanner_pkg::*;
(
   input  logic [11:0] scratch,
   input  logic [7:0]  bin,
   output logic [11:0] scratch_next,
   output logic [7:0]  bin_next
);

   logic [11:0] adj_s;
   logic [19:0] shifted_s;

   assign adj_s = {add3_adjust(scratch[11:8]), add3_adjust(scratch[7:4]), add3_adjust(scratch[3:0])};
   assign shifted_s = {adj_s, bin} << 1;
   assign scratch_next = shifted_s[19:8];
   assign bin_next     = shifted_s[7:0];

endmodule

// File: rtl/bcd_digit_scanner.sv
// Accepts an 8-bit value, converts it to three BCD digits over eight cycles and
// time-multiplexes the committed digits onto a single 4-bit digit bus.
module bcd_digit_scanner
   import bcd_digit_scanner_pkg::*;
#(
   parameter int SCAN_DIV      = 1024,
   parameter bit BLANK_LEADING = 1'b1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  value,
   input  logic        value_valid,
   output logic        value_ready,
   output logic        busy,
   output logic [11:0] bcd,
   output logic [3:0]  digit,
   output logic [1:0]  digit_place,
   output logic        digit_blank
);

   localparam int PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(SCAN_DIV - 1);
   localparam logic [2:0] ITER_LAST = 3'(ITERATIONS - 1);

   logic [1:0]      state_r;
   logic [2:0]      iter_r;
   logic [11:0]     scratch_r;
   logic [7:0]      bin_r;
   bcd_t            bcd_r;
   logic [1:0]      place_r;
   logic [PS_W-1:0] prescale_r;
   logic [11:0]     scratch_nx_s;
   logic [7:0]      bin_nx_s;

   bcd_digit_scanner_dabble_step u_dabble_step (
      .scratch      (scratch_r),
      .bin          (bin_r),
      .scratch_next (scratch_nx_s),
      .bin_next     (bin_nx_s)
   );

   // Conversion FSM; bcd_r only moves in COMMIT so a half-converted value is never shown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         iter_r    <= 3'd0;
         scratch_r <= 12'h000;
         bin_r     <= 8'h00;
         bcd_r     <= 12'h000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (value_valid) begin
                  state_r   <= ST_CONVERT;
                  scratch_r <= 12'h000;
                  bin_r     <= value;
                  iter_r    <= 3'd0;
               end
            end
            ST_CONVERT: begin
               scratch_r <= scratch_nx_s;
               bin_r     <= bin_nx_s;
               iter_r    <= iter_r + 3'd1;
               if (iter_r == ITER_LAST) begin
                  state_r <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               bcd_r   <= scratch_r;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Free-running scan prescaler and place rotation, independent of the conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_r <= '0;
         place_r    <= PLACE_ONES;
      end else if (prescale_r == PS_MAX) begin
         prescale_r <= '0;
         if (place_r == PLACE_HUNDREDS) begin
            place_r <= PLACE_ONES;
         end else begin
            place_r <= place_r + 2'd1;
         end
      end else begin
         prescale_r <= prescale_r + 1'b1;
      end
   end

   // Digit mux and leading-zero blanking for the current place.
   always_comb begin
      digit       = 4'h0;
      digit_blank = 1'b0;
      case (place_r)
         PLACE_ONES:     digit = bcd_r.ones;
         PLACE_TENS:     digit = bcd_r.tens;
         PLACE_HUNDREDS: digit = bcd_r.hundreds;
         default:        digit = 4'h0;
      endcase
      if (BLANK_LEADING) begin
         case (place_r)
            PLACE_TENS:     digit_blank = (bcd_r.hundreds == 4'h0) && (bcd_r.tens == 4'h0);
            PLACE_HUNDREDS: digit_blank = (bcd_r.hundreds == 4'h0);
            default:        digit_blank = 1'b0;
         endcase
      end else begin
         digit_blank = 1'b0;
      end
   end

   assign value_ready = (state_r == ST_IDLE);
   assign busy        = (state_r != ST_IDLE);
   assign bcd         = bcd_r;
   assign digit_place = place_r;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Randomized self-checking bench: a cycle-level transaction model (9-cycle busy window,
// decimal arithmetic, place = edges/SCAN_DIV mod 3) is compared with the DUT every cycle.
module tb_bcd_digit_scanner;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  value;
   logic        value_valid;
   logic        value_ready;
   logic        busy;
   logic [11:0] bcd;
   logic [3:0]  digit;
   logic [1:0]  digit_place;
   logic        digit_blank;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_cnt  = 0;   // remaining busy edges
   int m_val  = 0;   // committed binary value
   int m_pend = 0;   // value in flight
   int m_cyc  = 0;   // edges since reset release

   bcd_digit_scanner #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .busy        (busy),
      .bcd         (bcd),
      .digit       (digit),
      .digit_place (digit_place),
      .digit_blank (digit_blank)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_val = 0; m_pend = 0; m_cyc = 0;
   endtask

   task automatic check_outputs();
      int pl, h, t, o, ed, eb;
      pl = (m_cyc / SD) % 3;
      h  = m_val / 100;
      t  = (m_val / 10) % 10;
      o  = m_val % 10;
      ed = (pl == 0) ? o : (pl == 1) ? t : h;
      eb = (pl == 2) ? int'(h == 0) : (pl == 1) ? int'(h == 0 && t == 0) : 0;
      check_eq("ready", 32'(value_ready), 32'(m_cnt == 0));
      check_eq("busy", 32'(busy), 32'(m_cnt != 0));
      check_eq("bcd", 32'(bcd), 32'(to_bcd(m_val)));
      check_eq("place", 32'(digit_place), 32'(pl));
      check_eq("digit", 32'(digit), 32'(ed));
      check_eq("blank", 32'(digit_blank), 32'(eb));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         m_cyc++;
         if (m_cnt == 0) begin
            if (value_valid) begin
               m_cnt  = 9;
               m_pend = int'(value);
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) m_val = m_pend;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic send(input int v);
      int n;
      n = 0;
      while (value_ready !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      if (n >= 30) check_eq("ready_timeout", 32'(value_ready), 32'd1);
      value       = 8'(v);
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
   endtask

   initial begin
      int lowcnt;
      rst_n = 1'b0;
      value = 8'h00;
      value_valid = 1'b0;
      model_reset();
      // reset held while inputs toggle
      repeat (4) begin
         value       = 8'($urandom);
         value_valid = 1'($urandom);
         tick();
      end
      value_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) tick();

      // max value: ready low for exactly nine sampled cycles
      send(255);
      lowcnt = 0;
      while (value_ready === 1'b0 && lowcnt < 20) begin
         lowcnt++;
         tick();
      end
      check_eq("max_busy_len", 32'(lowcnt), 32'd9);
      check_eq("max_bcd", 32'(bcd), 32'h255);
      repeat (12) tick();

      // blanking cases and scan sequence
      send(0);   repeat (21) tick();
      send(7);   repeat (21) tick();
      send(100); repeat (21) tick();
      send(123); repeat (21) tick();

      // back-to-back with valid held high
      value = 8'd42; value_valid = 1'b1;
      tick();
      repeat (2) tick();
      value = 8'd199;
      repeat (7) tick();
      check_eq("b2b_first", 32'(bcd), 32'h042);
      repeat (10) tick();
      check_eq("b2b_second", 32'(bcd), 32'h199);
      value_valid = 1'b0;
      repeat (12) tick();

      // reset in the middle of a conversion
      send(200);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #2;
      rst_n = 1'b1;
      send(58);
      repeat (9) tick();
      check_eq("post_reset_bcd", 32'(bcd), 32'h058);

      // randomized traffic
      repeat (40) begin
         repeat ($urandom_range(0, 3)) tick();
         value       = 8'($urandom_range(0, 255));
         value_valid = 1'b1;
         repeat ($urandom_range(1, 12)) tick();
         value_valid = 1'b0;
      end
      repeat (15) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_digit_scanner.md
Name: bcd_digit_scanner

Overview:
- Sits downstream of the serial decode stage and upstream of the decimal seven-segment decoder.
- Accepts an 8-bit binary value through a valid/ready handshake and converts it to three BCD digits with a sequential double-dabble (one shift per cycle).
- Holds the result in display registers and time-multiplexes the digits onto one 4-bit digit bus with a place index, one place at a time.
- Optionally blanks leading zeros.

Parameters:
- SCAN_DIV, 1024: clock cycles each digit place is shown. Legal range >= 1.
- BLANK_LEADING, 1: 1 blanks leading zero digits; 0 always shows all three digits.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  8  binary value to display
- value_valid  in  1  upstream asserts when value is meaningful
- value_ready  out  1  high when the block can accept a value
- busy  out  1  conversion in progress (equals !value_ready)
- bcd  out  12  committed display value {hundreds, tens, ones}
- digit  out  4  BCD nibble for the current place
- digit_place  out  2  current place: 0=ones, 1=tens, 2=hundreds; 3 never driven
- digit_blank  out  1  current place must be shown blank

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, value_ready=1, busy=0, bcd=12'h000, digit_place=0, prescaler=0.
  - digit=0, digit_blank=0.
- Handshake:
  - Transfer occurs on a rising edge with value_valid && value_ready.
  - value is captured into an internal shift register on that edge; call this edge E0.
  - value_valid while not ready is ignored, not queued. Upstream holds value until ready.
- FSM states: IDLE -> CONVERT -> COMMIT -> IDLE.
  - IDLE: on transfer, go to CONVERT, clear scratch BCD, iter=0.
  - CONVERT: each edge first adds 3 to every scratch nibble >= 5, then shifts {scratch, bin} left by 1. iter increments. After the 8th shift (edge E8), go to COMMIT.
  - COMMIT: on edge E9, bcd <= scratch, then go to IDLE.
- Timing:
  - value_ready is low from just after E0 until just after E9.
  - A new transfer is possible on E10 at the earliest.
  - Total latency: the new bcd is visible 9 cycles after the accept edge.
- Arithmetic:
  - Scratch is 12 bits; the maximum input 255 yields 0x255. No overflow is possible.
  - The hundreds nibble never exceeds 2.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On the wrap edge, digit_place advances 0->1->2->0.
  - With SCAN_DIV=1, digit_place advances every cycle.
- digit output:
  - Combinational mux of bcd by digit_place.
  - bcd changes only at COMMIT, so a partial conversion is never displayed.
- Blanking (BLANK_LEADING=1):
  - place 2 is blanked when hundreds==0.
  - place 1 is blanked when hundreds==0 && tens==0.
  - place 0 is never blanked.
  - BLANK_LEADING=0: digit_blank is tied 0.
- Simultaneous events:
  - A COMMIT edge coinciding with a scan wrap: the new place shows the new bcd immediately.
  - value_valid held high continuously: the block re-accepts the current value every 10 cycles. Legal.
- Reset mid-operation: aborts the conversion, restores all reset values, and discards the pending value.

Decomposition:
- Shared package holds:
  - place constants PLACE_ONES=2'd0, PLACE_TENS=2'd1, PLACE_HUNDREDS=2'd2
  - FSM state encoding (IDLE, CONVERT, COMMIT)
  - ITERATIONS=8
- One sub-module: dabble_step, combinational. Takes 12-bit scratch + 8-bit bin, returns the adjusted-and-shifted pair; instantiated once.

Test Plan:
- Reset: hold rst_n low, toggle inputs -> bcd=000, digit_place=0, value_ready=1, digit=0, digit_blank=0; release with no valid -> no change except scan.
- Max value: value=255 accepted at E0 -> value_ready low for exactly 9 edges; bcd=12'h255 after E9; ready high after E9.
- Blanking: value=0 -> place0 digit 0 unblanked, places 1,2 blank; value=7 -> places 1,2 blank; value=100 -> no place blank (tens shows 0).
- Scan timing with SCAN_DIV=4, value=123 -> place/digit sequence (0,3),(1,2),(2,1),(0,3), each held 4 cycles.
- Back-to-back: value_valid held high, value=42 then switched to 199 during busy -> first bcd=042, 199 ignored until ready, accepted at E10, bcd=199 after E19.
- Reset mid-conversion: pulse rst_n low at CONVERT iter 4 of value=200 -> bcd=000, ready=1; then value=58 -> bcd=058 after 9 cycles.
